// File: rtl/unidade_io_pkg.sv
// Shared types and constants for the IN/OUT/HLT unit and its button debouncer.
package unidade_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE,
    HALTED
  } state_t;

  localparam int SW_W       = 16;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/unidade_io_debounce_botao.sv
// Two-flop synchronizer plus debouncer for the active-low confirm button.
// Emits one-cycle pulses when the debounced level changes to pressed or released.
module debounce_botao #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o,
  output logic rel_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count samples that disagree with the accepted level; any agreeing sample restarts it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
        rel_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;
  assign rel_o   = rel_q;

endmodule

// File: rtl/unidade_io.sv
// CPU I/O unit: user-mode IN waits for a debounced button press/release, OUT
// latches a display register, OS-serviced IN/OUT raise a trap, HLT stops the CPU.
module unidade_io
  import unidade_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DATA_W          = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SIn,
  input  logic              OutWrite,
  input  logic              SHlt,
  input  logic              S_Out_IN,
  input  logic              S_crtl,
  input  logic [SW_W-1:0]   sw_data,
  input  logic              btn_confirm_n,
  input  logic [DATA_W-1:0] out_data,
  output logic              stall,
  output logic [DATA_W-1:0] in_value,
  output logic              in_ready,
  output logic [DATA_W-1:0] display_reg,
  output logic              out_valid,
  output logic              io_trap,
  output logic              halted
);

  state_t            state_q;
  logic              stall_q, in_ready_q, out_valid_q, io_trap_q, halted_q;
  logic [DATA_W-1:0] in_value_q, display_q;
  logic              btn_press, btn_rel;
  logic              in_start;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_n_i(btn_confirm_n),
    .press_o(btn_press),
    .rel_o  (btn_rel)
  );

  // The PC must freeze in the very cycle a user IN is decoded, before the FSM registers it.
  assign in_start = (state_q == IDLE) && !SHlt && SIn && !S_crtl && S_Out_IN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stall_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      io_trap_q   <= 1'b0;
      halted_q    <= 1'b0;
      in_value_q  <= '0;
      display_q   <= '0;
    end else begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      io_trap_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (SHlt) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
            stall_q  <= 1'b1;
          end else if (SIn) begin
            if (S_crtl) begin
              io_trap_q <= 1'b1;
            end else if (S_Out_IN) begin
              state_q <= WAIT_PRESS;
              stall_q <= 1'b1;
            end
          end else if (OutWrite) begin
            if (S_crtl) begin
              io_trap_q <= 1'b1;
            end else if (S_Out_IN) begin
              display_q   <= out_data;
              out_valid_q <= 1'b1;
            end
          end
        end
        WAIT_PRESS: begin
          // Only a fresh press edge counts, so a button held on entry is ignored.
          if (btn_press) begin
            in_value_q <= DATA_W'(sw_data);
            state_q    <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (btn_rel) begin
            state_q    <= DONE;
            stall_q    <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        HALTED: begin
          halted_q <= 1'b1;
          stall_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stall       = stall_q | in_start;
  assign in_value    = in_value_q;
  assign in_ready    = in_ready_q;
  assign display_reg = display_q;
  assign out_valid   = out_valid_q;
  assign io_trap     = io_trap_q;
  assign halted      = halted_q;

endmodule

// File: doc/unidade_io.md
UNIDADE_IO -- requirements
Module: unidade_io

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to accept a button level change.
REQ-002 Parameter DATA_W, default 32: width of the register-file data path.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SIn  input  1: decoder flag, current instruction is IN.
REQ-006 OutWrite  input  1: decoder flag, current instruction is OUT.
REQ-007 SHlt  input  1: decoder flag, current instruction is HLT.
REQ-008 S_Out_IN  input  1: IN/OUT is performed by hardware for the user program.
REQ-009 S_crtl  input  1: IN/OUT is handed to the OS via trap.
REQ-010 sw_data  input  16: raw switch value for IN.
REQ-011 btn_confirm_n  input  1: raw, asynchronous, active-low confirm button.
REQ-012 out_data  input  DATA_W: register value for OUT.
REQ-013 stall  output  1: freezes the PC and suppresses register/memory writes.
REQ-014 in_value  output  DATA_W: data supplied to the register write-back mux.
REQ-015 in_ready  output  1: one-cycle qualifier; IN write-back is valid this cycle.
REQ-016 display_reg  output  DATA_W: last OUT value, held.
REQ-017 out_valid  output  1: one-cycle pulse after display_reg is updated.
REQ-018 io_trap  output  1: one-cycle request to the OS for OS-serviced IN/OUT.
REQ-019 halted  output  1: CPU is halted.

Function
REQ-020 The FSM SHALL have exactly these states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE, HALTED.
REQ-021 btn_confirm_n SHALL pass through a 2-flop synchronizer, then the debouncer; "pressed" means the debounced level is 0.
REQ-022 The debounced level SHALL change only after DEBOUNCE_CYCLES consecutive equal synchronized samples; any mismatch restarts the count.
REQ-023 In IDLE, inputs SHALL be evaluated with priority SHlt > SIn > OutWrite; for a single IN/OUT, S_crtl takes priority over S_Out_IN.
REQ-024 IDLE with SHlt: go to HALTED; halted=1 and stall=1 from the next cycle until reset.
REQ-025 IDLE with SIn and S_crtl: io_trap=1 for exactly one cycle; stay in IDLE; no stall.
REQ-026 IDLE with SIn and S_Out_IN (S_crtl=0): go to WAIT_PRESS; stall SHALL be 1 combinationally in that same cycle.
REQ-027 WAIT_PRESS: stall=1; on the debounced press, register in_value = zero-extended sw_data and go to WAIT_RELEASE.
REQ-028 WAIT_RELEASE: stall=1; on the debounced release, go to DONE.
REQ-029 DONE: stall=0 and in_ready=1 for exactly one cycle; return to IDLE unconditionally, ignoring the still-asserted SIn.
REQ-030 IDLE with OutWrite and S_crtl: io_trap=1 for exactly one cycle; display_reg is unchanged.
REQ-031 IDLE with OutWrite and S_Out_IN (S_crtl=0): on that edge display_reg <= out_data; out_valid=1 in the following cycle; no stall; stay in IDLE.
REQ-032 in_value SHALL hold its last captured value until the next capture.
REQ-033 If SIn/OutWrite are asserted with neither S_Out_IN nor S_crtl, the instruction SHALL be treated as NOP: no stall, trap or update.
REQ-034 A button press already active when WAIT_PRESS is entered SHALL NOT satisfy WAIT_PRESS; a release and a new press are required.

Reset
REQ-035 On rst_n=0, regardless of state:
  - state = IDLE
  - stall, in_ready, out_valid, io_trap and halted = 0
  - in_value and display_reg = 0
  - synchronizer flops = 1, debounced level = released, debounce counter = 0
REQ-036 Reset asserted mid-wait (WAIT_PRESS or WAIT_RELEASE) SHALL abandon the IN with no in_ready pulse.

Structure
REQ-037 A shared package SHALL hold the FSM state enumeration, the 16-bit switch width constant, and the DATA_W default.
REQ-038 Synchronizer plus debouncer SHALL be one sub-module, debounce_botao, parameterized by DEBOUNCE_CYCLES.

Verification
REQ-039 User IN: SIn=1, S_Out_IN=1, sw_data=16'h00A5; press held 6 cycles, then released -> stall high throughout, in_ready single pulse with in_value=32'h000000A5, then stall=0.
REQ-040 Bounce: button toggles every 2 cycles with DEBOUNCE_CYCLES=4 -> stays in WAIT_PRESS; a stable press is then accepted exactly once.
REQ-041 User OUT: OutWrite=1, S_Out_IN=1, out_data=32'hDEADBEEF -> display_reg=32'hDEADBEEF, out_valid pulse 1 cycle, stall never asserted.
REQ-042 OS IN/OUT: SIn=1, S_crtl=1, then OutWrite=1, S_crtl=1 -> two single-cycle io_trap pulses; display_reg and in_value unchanged.
REQ-043 HLT then IN: SHlt=1 for one cycle, then SIn=1 -> halted=1 and stall=1 persist; no in_ready; rst_n low clears both.
REQ-044 Reset in WAIT_RELEASE: rst_n pulsed low -> IDLE, all outputs 0, no in_ready pulse.
